// File: rtl/life_pkg.sv
// Shared constants, FSM state type and the B3/S23 rule for the Life step engine.
package life_pkg;

   localparam int LIFE_COLS = 2198;
   localparam int LIFE_ROWS = 1125;
   localparam int NCNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } life_state_e;

   function automatic logic [NCNT_W-1:0] life_count(input logic [7:0] nb);
      logic [NCNT_W-1:0] sum;
      sum = 4'd0;
      for (int i = 0; i < 8; i++) begin
         sum = sum + {3'd0, nb[i]};
      end
      return sum;
   endfunction

   function automatic logic life_rule(input logic centre, input logic [NCNT_W-1:0] n,
                                      input logic run);
      logic nxt;
      if (run) begin
         nxt = (n == 4'd3) | (centre & (n == 4'd2));
      end else begin
         nxt = centre;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/life_step_line_delay.sv
// COLS-deep enabled 1-bit delay: a (COLS-1)-entry read-before-write RAM plus its output register.
module life_line_delay #(
   parameter int COLS = 2198
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic din,
   output logic dout
);
   localparam int DEPTH = COLS - 1;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          mem_q [DEPTH];
   logic [PW-1:0] ptr_q;
   logic          dout_q;

   // Storage array carries no reset so it can sit in block RAM; stale contents are masked downstream
   always_ff @(posedge clock) begin
      if (enable) begin
         mem_q[ptr_q] <= din;
      end
   end

   // Read port register and circular pointer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q  <= {PW{1'b0}};
         dout_q <= 1'b0;
      end else if (enable) begin
         dout_q <= mem_q[ptr_q];
         if (ptr_q == PW'(DEPTH - 1)) begin
            ptr_q <= {PW{1'b0}};
         end else begin
            ptr_q <= ptr_q + PW'(1);
         end
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/life_step.sv
// Streaming B3/S23 next-generation engine for the Life cell ring.
// Optional frame population counter enabled by defining LIFE_STATS_EN.
module life_step
   import life_pkg::*;
#(
   parameter int COLS = LIFE_COLS,
   parameter int ROWS = LIFE_ROWS
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               sof,
   input  logic                               cell_in,
   input  logic                               run,
   output logic                               cell_out,
   output logic                               cell_valid,
   output logic [$clog2(COLS*ROWS+1)-1:0]     population
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int FW = $clog2(COLS + 2);
   localparam int PW = $clog2(COLS * ROWS + 1);

   life_state_e   state_q;
   logic [CW-1:0] in_col_q, in_col_d, pos_col_s, cen_col_s;
   logic [RW-1:0] in_row_q, in_row_d, pos_row_s, cen_row_s;
   logic [FW-1:0] fill_q;
   logic [1:0]    win_top_q, win_mid_q, win_bot_q;
   logic [2:0]    top_win_s, mid_win_s, bot_win_s;
   logic [2:0]    top_m_s, mid_m_s, bot_m_s, col_mask_s;
   logic [7:0]    nb_s;
   logic          dly1_out_s, dly2_out_s;
   logic          next_cell_s, resync_s;
   logic          cell_out_q, cell_valid_q;

   life_line_delay #(.COLS(COLS)) u_dly1 (
      .clock(clock), .reset(reset), .enable(enable), .din(cell_in),    .dout(dly1_out_s)
   );
   life_line_delay #(.COLS(COLS)) u_dly2 (
      .clock(clock), .reset(reset), .enable(enable), .din(dly1_out_s), .dout(dly2_out_s)
   );

   // Position of the accepted cell, next input counters and the centre it completes
   always_comb begin
      if (sof) begin
         pos_col_s = {CW{1'b0}};
         pos_row_s = {RW{1'b0}};
      end else begin
         pos_col_s = in_col_q;
         pos_row_s = in_row_q;
      end
      if (pos_col_s == CW'(COLS - 1)) begin
         in_col_d = {CW{1'b0}};
         if (pos_row_s == RW'(ROWS - 1)) begin
            in_row_d = {RW{1'b0}};
         end else begin
            in_row_d = pos_row_s + RW'(1);
         end
      end else begin
         in_col_d = pos_col_s + CW'(1);
         in_row_d = pos_row_s;
      end
      // Centre trails the input by COLS+1 cells: one column and one row back, modulo the frame
      if (pos_col_s == {CW{1'b0}}) begin
         cen_col_s = CW'(COLS - 1);
         if (pos_row_s >= RW'(2)) begin
            cen_row_s = pos_row_s - RW'(2);
         end else begin
            cen_row_s = pos_row_s + RW'(ROWS - 2);
         end
      end else begin
         cen_col_s = pos_col_s - CW'(1);
         if (pos_row_s != {RW{1'b0}}) begin
            cen_row_s = pos_row_s - RW'(1);
         end else begin
            cen_row_s = RW'(ROWS - 1);
         end
      end
      resync_s = sof && ((in_col_q != {CW{1'b0}}) || (in_row_q != {RW{1'b0}}));
   end

   // Post-shift 3x3 window (bit2 = left, bit1 = centre, bit0 = right), border masking and rule
   always_comb begin
      top_win_s = {win_top_q, dly2_out_s};
      mid_win_s = {win_mid_q, dly1_out_s};
      bot_win_s = {win_bot_q, cell_in};
      if (cen_col_s == {CW{1'b0}}) begin
         col_mask_s[2] = 1'b0;
      end else begin
         col_mask_s[2] = 1'b1;
      end
      col_mask_s[1] = 1'b1;
      if (cen_col_s == CW'(COLS - 1)) begin
         col_mask_s[0] = 1'b0;
      end else begin
         col_mask_s[0] = 1'b1;
      end
      if (cen_row_s == {RW{1'b0}}) begin
         top_m_s = 3'b000;
      end else begin
         top_m_s = top_win_s & col_mask_s;
      end
      if (cen_row_s == RW'(ROWS - 1)) begin
         bot_m_s = 3'b000;
      end else begin
         bot_m_s = bot_win_s & col_mask_s;
      end
      mid_m_s     = mid_win_s & col_mask_s;
      nb_s        = {top_m_s, mid_m_s[2], mid_m_s[0], bot_m_s};
      next_cell_s = life_rule(mid_win_s[1], life_count(nb_s), run);
   end

   // Control FSM, counters, window shift and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         in_col_q     <= {CW{1'b0}};
         in_row_q     <= {RW{1'b0}};
         fill_q       <= {FW{1'b0}};
         win_top_q    <= 2'b00;
         win_mid_q    <= 2'b00;
         win_bot_q    <= 2'b00;
         cell_out_q   <= 1'b0;
         cell_valid_q <= 1'b0;
      end else if (enable) begin
         in_col_q  <= in_col_d;
         in_row_q  <= in_row_d;
         win_top_q <= top_win_s[1:0];
         win_mid_q <= mid_win_s[1:0];
         win_bot_q <= bot_win_s[1:0];
         case (state_q)
            ST_IDLE: begin
               cell_out_q   <= 1'b0;
               cell_valid_q <= 1'b0;
               if (sof) begin
                  state_q <= ST_FILL;
                  fill_q  <= FW'(1);
               end
            end
            ST_FILL: begin
               cell_out_q   <= 1'b0;
               cell_valid_q <= 1'b0;
               if (resync_s) begin
                  fill_q <= FW'(1);
               end else if (fill_q == FW'(COLS)) begin
                  state_q <= ST_RUN;
               end else begin
                  fill_q <= fill_q + FW'(1);
               end
            end
            ST_RUN: begin
               if (resync_s) begin
                  state_q      <= ST_FILL;
                  fill_q       <= FW'(1);
                  cell_out_q   <= 1'b0;
                  cell_valid_q <= 1'b0;
               end else begin
                  cell_out_q   <= next_cell_s;
                  cell_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               cell_out_q   <= 1'b0;
               cell_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cell_out   = cell_out_q;
   assign cell_valid = cell_valid_q;

`ifdef LIFE_STATS_EN
   logic [PW-1:0] live_cnt_q, pop_q, live_sum_s;
   logic          emit_s, last_cell_s;

   assign emit_s      = (state_q == ST_RUN) && !resync_s;
   assign last_cell_s = (cen_row_s == RW'(ROWS - 1)) && (cen_col_s == CW'(COLS - 1));
   assign live_sum_s  = live_cnt_q + {{(PW-1){1'b0}}, next_cell_s};

   // Live-cell tally, latched into population as the frame's last centre is emitted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         live_cnt_q <= {PW{1'b0}};
         pop_q      <= {PW{1'b0}};
      end else if (enable && emit_s) begin
         if (last_cell_s) begin
            pop_q      <= live_sum_s;
            live_cnt_q <= {PW{1'b0}};
         end else begin
            live_cnt_q <= live_sum_s;
         end
      end
   end

   assign population = pop_q;
`else
   assign population = {PW{1'b0}};
`endif

endmodule
